// File: rtl/cache_writeback_unit.sv
// cache_writeback_unit
// Drains one dirty cache line to memory as a single AXI3 INCR write burst.
// The line is read from a registered-read storage port (one-cycle latency).
// Words stream through a 2-entry buffer onto the W channel, and AW is
// issued in parallel with W. The unit then waits for B and reports either
// wb_done or wb_err.
// Optional feature: define CACHE_WB_RETRY_EN to replay the whole burst once
// after the first non-OKAY write response.
//
// Handshake rule used on every AXI channel: a transfer happens on a rising
// clk edge where valid and ready are both high. Once valid is raised, it and
// its payload stay stable until that transfer. The ready inputs may toggle
// freely.
module cache_writeback_unit #(
    parameter int         CACHE_LINE_WIDTH = 6,
    parameter int         TAG_WIDTH        = 20,
    parameter int         INDEX_WIDTH      = 6,
    parameter int         OFFSET_WIDTH     = CACHE_LINE_WIDTH - 2,
    parameter logic [3:0] AXI_ID           = 4'd1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_req,
    input  logic [TAG_WIDTH-1:0]    wb_tag,
    input  logic [INDEX_WIDTH-1:0]  wb_index,
    output logic                    wb_idle,
    output logic                    wb_done,
    output logic                    wb_err,
    output logic [OFFSET_WIDTH-1:0] line_roff,
    input  logic [31:0]             line_rdata,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [3:0]              wid,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [3:0]              bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam int              PW        = OFFSET_WIDTH + 1;
    localparam logic [PW-1:0]   N_BEATS   = PW'(2 ** OFFSET_WIDTH);
    localparam logic [PW-1:0]   LAST_BEAT = PW'(2 ** OFFSET_WIDTH - 1);
    localparam logic [3:0]      AWLEN_C   = 4'(2 ** OFFSET_WIDTH - 1);

    // FSM state, kept as a named register so checkers can bind to it
    logic [1:0]    state;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] beat_cnt;
    logic          rd_inflight;
    logic [31:0]   buf0;
    logic [31:0]   buf1;
    logic [1:0]    buf_cnt;
    logic          aw_done;
    logic          w_done;
    logic          awvalid_q;
    logic [31:0]   awaddr_q;
    logic          done_q;
    logic          err_q;

    logic accept;
    logic rd_issue;
    logic aw_hs;
    logic w_hs;
    logic burst_end;
    logic b_hs;
    logic bresp_ok;
    logic do_retry;
    logic restart;
    logic push;
    logic pop_buf;

    // bid is not needed, because only one transaction is ever outstanding
    logic unused_bid;
    assign unused_bid = ^bid;

    // Handshake and sequencing decisions derived from the registered state
    always_comb begin
        wb_idle   = (state == S_IDLE) && !done_q && !err_q;
        accept    = wb_idle && wb_req;
        wvalid    = (buf_cnt != 2'd0) || rd_inflight;
        wlast     = wvalid && (beat_cnt == LAST_BEAT);
        aw_hs     = awvalid_q && awready;
        w_hs      = wvalid && wready;
        rd_issue  = (state == S_BURST) && (rd_ptr < N_BEATS) &&
                    ((3'(buf_cnt) + 3'(rd_inflight)) < 3'd2);
        burst_end = (state == S_BURST) && (aw_done || aw_hs) &&
                    (w_done || (w_hs && wlast));
        b_hs      = (state == S_RESP) && bvalid;
        bresp_ok  = (bresp == 2'b00);
        // When the buffer is empty, the word arriving from storage goes out directly
        push      = rd_inflight && !(w_hs && (buf_cnt == 2'd0));
        pop_buf   = w_hs && (buf_cnt != 2'd0);
        if (buf_cnt != 2'd0) begin
            wdata = buf0;
        end else if (rd_inflight) begin
            wdata = line_rdata;
        end else begin
            wdata = '0;
        end
    end

`ifdef CACHE_WB_RETRY_EN
    logic retry_q;

    // Decide whether the first failed response triggers a replay
    always_comb begin
        do_retry = b_hs && !bresp_ok && !retry_q;
    end

    // Track whether the one allowed replay has been used for this line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retry_q <= 1'b0;
        end else if (do_retry) begin
            retry_q <= 1'b1;
        end else if (b_hs) begin
            retry_q <= 1'b0;
        end
    end
`else
    // Without the replay feature, every failed response is final
    always_comb begin
        do_retry = 1'b0;
    end
`endif

    assign restart = accept || do_retry;

    // Main sequencing FSM and the completion pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            awaddr_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= S_BURST;
                        awaddr_q <= {wb_tag, wb_index, {CACHE_LINE_WIDTH{1'b0}}};
                    end
                end
                S_BURST: begin
                    if (burst_end) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (b_hs) begin
                        if (do_retry) begin
                            state <= S_BURST;
                        end else begin
                            state  <= S_IDLE;
                            done_q <= bresp_ok;
                            err_q  <= !bresp_ok;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // AW channel: raise awvalid at burst start and hold it until the handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b0;
        end else if (restart) begin
            awvalid_q <= 1'b1;
            aw_done   <= 1'b0;
        end else if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
        end
    end

    // Read pointer, beat counter and 2-entry word buffer
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            rd_ptr      <= '0;
            beat_cnt    <= '0;
            rd_inflight <= 1'b0;
            buf_cnt     <= 2'd0;
            buf0        <= '0;
            buf1        <= '0;
            w_done      <= 1'b0;
        end else begin
            rd_inflight <= rd_issue;
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (w_hs) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (wlast) begin
                    w_done <= 1'b1;
                end
            end
            if (pop_buf && push) begin
                if (buf_cnt == 2'd1) begin
                    buf0 <= line_rdata;
                end else begin
                    buf0 <= buf1;
                    buf1 <= line_rdata;
                end
            end else if (pop_buf) begin
                buf0    <= buf1;
                buf_cnt <= buf_cnt - 2'd1;
            end else if (push) begin
                if (buf_cnt == 2'd0) begin
                    buf0 <= line_rdata;
                end else begin
                    buf1 <= line_rdata;
                end
                buf_cnt <= buf_cnt + 2'd1;
            end
        end
    end

    assign line_roff = rd_ptr[OFFSET_WIDTH-1:0];
    assign awid      = AXI_ID;
    assign awaddr    = awaddr_q;
    assign awlen     = AWLEN_C;
    assign awsize    = 3'b010;
    assign awburst   = 2'b01;
    assign awvalid   = awvalid_q;
    assign wid       = AXI_ID;
    assign wstrb     = 4'hF;
    assign bready    = (state == S_RESP);
    assign wb_done   = done_q;
    assign wb_err    = err_q;

endmodule

// File: tb/tb_cache_writeback_unit.sv
// tb_cache_writeback_unit
// Randomized bench for cache_writeback_unit. A storage model provides the
// registered line read port. The expected W data stream is a queue filled
// from the line contents, with one copy per burst the outcome rules call for.
module tb_cache_writeback_unit;

    localparam int NB = 16;

    logic        clk;
    logic        rst_n;
    logic        wb_req;
    logic [19:0] wb_tag;
    logic [5:0]  wb_index;
    logic        wb_idle;
    logic        wb_done;
    logic        wb_err;
    logic [3:0]  line_roff;
    logic [31:0] line_rdata;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [31:0] mem [NB];
    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    cache_writeback_unit dut (
        .clk(clk), .rst_n(rst_n), .wb_req(wb_req), .wb_tag(wb_tag),
        .wb_index(wb_index), .wb_idle(wb_idle), .wb_done(wb_done),
        .wb_err(wb_err), .line_roff(line_roff), .line_rdata(line_rdata),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp),
        .bvalid(bvalid), .bready(bready)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Line storage with a registered read port
    always @(posedge clk) line_rdata <= mem[line_roff];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_wb_idle", 32'(wb_idle), 32'd1);
        check("rst_wb_done", 32'(wb_done), 32'd0);
        check("rst_wb_err", 32'(wb_err), 32'd0);
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid", 32'(wvalid), 32'd0);
        check("rst_wlast", 32'(wlast), 32'd0);
        check("rst_bready", 32'(bready), 32'd0);
        check("rst_line_roff", 32'(line_roff), 32'd0);
        check("rst_awaddr", awaddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NB; i++) mem[i] = $urandom();
    endtask

    // One complete writeback. wmode: 0 always ready, 1 toggling,
    // 2 random, 3 wready low for 20 cycles after the first wvalid.
    task automatic do_wb(input logic [19:0] tag, input logic [5:0] idx, input int wmode,
                         input int aw_delay, input logic [1:0] resp0, input logic [1:0] resp1,
                         input bit timing_chk, input bit req_during);
        int          c, bc, beat, total, nb, aw_hs, first_w, last_w, first_b, bdelay;
        logic [31:0] exp_addr, held_d, exp_d;
        logic        held_l, prev_stall, fin, retry, post_retry;
        logic [1:0]  resp_now;
        c = 0; bc = 0; beat = 0; total = 0; nb = 1; aw_hs = 0;
        first_w = -1; last_w = -1; first_b = -1; bdelay = $urandom_range(0, 3);
        held_d = '0; held_l = 1'b0; prev_stall = 1'b0; fin = 1'b0;
        post_retry = 1'b0; resp_now = 2'b00; retry = 1'b0;
        exp_addr = {tag, idx, 6'b0};
        exp_q.delete();
        for (int i = 0; i < NB; i++) exp_q.push_back(mem[i]);
        check("idle_before_req", 32'(wb_idle), 32'd1);
        wb_tag = tag;
        wb_index = idx;
        wb_req = 1'b1;
        @(negedge clk);
        wb_req = 1'b0;
        c = 1;
        bc = 1;
        while (!fin) begin
            if (post_retry) begin
                check("no_pulse_on_retry", {30'd0, wb_done, wb_err}, 32'd0);
                post_retry = 1'b0;
            end
            if (wvalid && first_w < 0) first_w = c;
            awready = (bc > aw_delay);
            case (wmode)
                0: wready = 1'b1;
                1: wready = c[0];
                2: wready = 1'($urandom_range(0, 1));
                default: wready = (first_w >= 0) && (c >= first_w + 20);
            endcase
            bvalid = 1'b0;
            if (bready) begin
                if (first_b < 0) first_b = c;
                if (bdelay == 0) begin
                    bvalid = 1'b1;
                    bresp = (nb == 1) ? resp0 : resp1;
                    bid = 4'd1;
                end else begin
                    bdelay--;
                end
            end
            if (req_during) begin
                wb_req = (c == 5);
                if (c == 5) wb_tag = 20'($urandom());
            end
            if (timing_chk && nb == 1 && c == 1) begin
                check("c1_awvalid", 32'(awvalid), 32'd1);
                check("c1_line_roff", 32'(line_roff), 32'd0);
            end
            if (wmode == 3 && first_w >= 0 && (c == first_w + 10 || c == first_w + 19))
                check("stall_line_roff", 32'(line_roff), 32'd2);
            if (awvalid && awready) begin
                aw_hs++;
                check("awaddr", awaddr, exp_addr);
                check("awlen", 32'(awlen), 32'(NB - 1));
                check("awsize", 32'(awsize), 32'd2);
                check("awburst", 32'(awburst), 32'd1);
                check("awid", 32'(awid), 32'd1);
            end
            if (wvalid && prev_stall) begin
                check("stall_wdata_hold", wdata, held_d);
                check("stall_wlast_hold", 32'(wlast), 32'(held_l));
            end
            if (wvalid && wready) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check("wdata", wdata, exp_d);
                check("wlast", 32'(wlast), 32'(beat == NB - 1));
                check("wid_wstrb", {24'd0, wid, wstrb}, {24'd0, 4'd1, 4'hF});
                if (wlast && nb == 1) last_w = c;
                beat++;
                total++;
            end
            prev_stall = wvalid && !wready;
            held_d = wdata;
            held_l = wlast;
            if (bvalid && bready) begin
                check("beats_before_b", 32'(beat), 32'(NB));
                resp_now = bresp;
                retry = 1'b0;
`ifdef CACHE_WB_RETRY_EN
                if (resp_now != 2'b00 && nb == 1) retry = 1'b1;
`endif
                if (retry) begin
                    nb++;
                    beat = 0;
                    bc = 0;
                    bdelay = $urandom_range(0, 3);
                    post_retry = 1'b1;
                    for (int i = 0; i < NB; i++) exp_q.push_back(mem[i]);
                end else begin
                    fin = 1'b1;
                end
            end
            if (c > 3000) begin
                check("timeout", 32'(c), 32'd0);
                fin = 1'b1;
            end
            @(negedge clk);
            c++;
            bc++;
        end
        bvalid = 1'b0;
        awready = 1'b0;
        wready = 1'b0;
        wb_req = 1'b0;
        check("wb_done_pulse", 32'(wb_done), 32'(resp_now == 2'b00));
        check("wb_err_pulse", 32'(wb_err), 32'(resp_now != 2'b00));
        check("idle_during_pulse", 32'(wb_idle), 32'd0);
        @(negedge clk);
        check("idle_after_pulse", 32'(wb_idle), 32'd1);
        check("pulse_single", {30'd0, wb_done, wb_err}, 32'd0);
        check("aw_handshakes", 32'(aw_hs), 32'(nb));
        check("total_beats", 32'(total), 32'(NB * nb));
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        if (timing_chk) begin
            check("first_wvalid_cycle", 32'(first_w), 32'd2);
            check("last_beat_cycle", 32'(last_w), 32'(NB + 1));
            check("first_bready_cycle", 32'(first_b), 32'(NB + 2));
        end
    endtask

    // Reset asserted after 7 beats must return every output to its reset value
    task automatic reset_mid_burst();
        int beat, guard;
        beat = 0;
        guard = 0;
        fill_random();
        wb_tag = 20'($urandom());
        wb_index = 6'($urandom());
        wb_req = 1'b1;
        @(negedge clk);
        wb_req = 1'b0;
        awready = 1'b1;
        wready = 1'b1;
        while (beat < 7 && guard < 200) begin
            if (wvalid && wready) beat++;
            if (beat < 7) begin
                @(negedge clk);
                guard++;
            end
        end
        check("reach_beat7", 32'(beat), 32'd7);
        rst_n = 1'b0;
        awready = 1'b0;
        wready = 1'b0;
        @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Main sequence: reset, directed scenarios, random writebacks, report
    initial begin
        logic [1:0] r0, r1;
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        wb_req = 1'b0;
        wb_tag = '0;
        wb_index = '0;
        awready = 1'b0;
        wready = 1'b0;
        bid = '0;
        bresp = '0;
        bvalid = 1'b0;
        for (int i = 0; i < NB; i++) mem[i] = 32'h1000_0000 + 32'(i);
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        do_wb(20'hABCDE, 6'h15, 0, 0, 2'b00, 2'b00, 1'b1, 1'b0);
        do_wb(20'hABCDE, 6'h15, 1, 10, 2'b00, 2'b00, 1'b0, 1'b0);
        do_wb(20'hABCDE, 6'h15, 3, 0, 2'b00, 2'b00, 1'b0, 1'b0);
        do_wb(20'hABCDE, 6'h15, 0, 0, 2'b10, 2'b00, 1'b0, 1'b0);
        do_wb(20'h12345, 6'h2A, 2, 3, 2'b11, 2'b01, 1'b0, 1'b0);
        fill_random();
        do_wb(20'h0F0F0, 6'h01, 0, 2, 2'b00, 2'b00, 1'b0, 1'b1);
        reset_mid_burst();
        do_wb(20'h55555, 6'h3F, 0, 0, 2'b00, 2'b00, 1'b1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            fill_random();
            r0 = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            r1 = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_wb(20'($urandom()), 6'($urandom()), int'($urandom_range(1, 2)),
                  int'($urandom_range(0, 12)), r0, r1, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_writeback_unit.md
# cache_writeback_unit

Drains one dirty cache line to memory as a single AXI3 INCR write burst. Sits between a cache way's line storage (registered read port, one-cycle latency) and the AXI write channels of the bus interface. On a victim writeback request it streams all words of the line out of storage, issues AW/W, waits for B, and reports completion or error to the cache controller.

## Interface
Parameters:
- CACHE_LINE_WIDTH, 6, log2 of line bytes
- TAG_WIDTH, 20, tag bits
- INDEX_WIDTH, 6, set index bits; TAG_WIDTH+INDEX_WIDTH+CACHE_LINE_WIDTH must equal 32
- OFFSET_WIDTH, CACHE_LINE_WIDTH-2, word offset bits; beats per burst N = 2**OFFSET_WIDTH
- AXI_ID, 4'd1, constant AWID/WID

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- wb_req  in  1  start writeback; sampled only when wb_idle=1
- wb_tag  in  TAG_WIDTH  victim tag
- wb_index  in  INDEX_WIDTH  victim set index
- wb_idle  out  1  unit idle, may accept wb_req
- wb_done  out  1  one-cycle pulse, burst finished with OKAY
- wb_err  out  1  one-cycle pulse, burst finished with non-OKAY (coincides with wb_done=0)
- line_roff  out  OFFSET_WIDTH  word offset driven to line storage read port
- line_rdata  in  32  storage read data, valid the cycle after line_roff is presented
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/4/3/2/1; awready in 1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1; wready in 1
- bid in 4, bresp in 2, bvalid in 1; bready out 1

## Operation
- States: IDLE, BURST, RESP.
- IDLE: wb_idle=1. wb_req=1 latches awaddr={wb_tag,wb_index,CACHE_LINE_WIDTH'b0}, clears counters, -> BURST.
- BURST: awvalid held until awready handshake, then low. awlen=N-1, awsize=3'b010, awburst=2'b01, wstrb=4'hF, wid=awid=AXI_ID.
- Read side: rd_ptr (OFFSET_WIDTH+1 bits) drives line_roff. A read is issued when rd_ptr<N and (buffered words + in-flight read) < 2; rd_ptr increments; line_rdata captured next cycle into a 2-entry buffer.
- Write side: wvalid=1 whenever buffer non-empty; wdata=buffer head; wlast=1 when beat counter = N-1. On wvalid&wready pop head, increment beat counter.
- W beats may complete before the AW handshake; ordering between channels is not enforced.
- Leave BURST to RESP when AW handshake done and last W beat handshaken (either order, same cycle allowed).
- RESP: bready=1. On bvalid: bresp==2'b00 -> wb_done pulse; else wb_err pulse. -> IDLE. bid is ignored.
- Storage contents of the victim line must not be modified while wb_idle=0; this is the controller's obligation.

## Timing
- Reset values: wb_idle=1, wb_done=0, wb_err=0, awvalid=0, wvalid=0, wlast=0, bready=0, line_roff=0, awaddr=0, wdata=0.
- Cycle 0 wb_req accepted; cycle 1 awvalid=1, line_roff=0; cycle 2 first wvalid=1.
- Zero back-pressure (awready=wready=1): one beat per cycle, last beat cycle N+1, bready from cycle N+2; wb_done the cycle after bvalid sampled; wb_idle=1 the cycle after that pulse.
- wready=0 stalls: buffer fills to 2, reads stop, wdata/wlast held stable; no word lost or duplicated.
- wb_req while wb_idle=0 ignored.
- rst_n low mid-burst: all state to reset values next edge; burst abandoned.

## Configuration
- CACHE_WB_RETRY_EN defined: on first non-OKAY bresp, no wb_err; unit returns to BURST, reissues AW and replays all N words from offset 0. Second non-OKAY -> wb_err. Retry flag cleared on return to IDLE.
- Undefined: any non-OKAY bresp -> wb_err immediately, no replay.

## Test plan
- wb_tag=20'hABCDE, wb_index=6'h15, line word i = 32'h1000_0000+i, all ready=1 -> awaddr=32'hABCDE540, awlen=15, 16 beats in order, wlast on beat 16 only, wb_done one cycle.
- Same, wready toggling 1/0 each cycle, awready delayed 10 cycles -> identical data sequence, wdata stable while stalled, single AW handshake.
- wready=0 for 20 cycles after first wvalid -> line_roff stops at 2, no further reads until pop.
- bresp=2'b10 without macro -> wb_err=1, wb_done=0; with CACHE_WB_RETRY_EN -> second full 16-beat burst, then OKAY -> wb_done.
- rst_n low at beat 7 -> all outputs reset values next cycle; new wb_req afterwards starts from offset 0.
- wb_req pulsed during BURST -> ignored, no second AW.
